// File: rtl/i2c_target_if.sv
// I2C pin bundle between a bus controller model and the i2c_target responder.
// The target only ever pulls SDA low (sda_oe); SCL is input-only on this side.
interface i2c_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target.sv
// I2C register-file responder: synchronises and glitch-filters SCL/SDA, matches ADDR,
// loads a register pointer, accepts writes and serves reads. Option: I2C_TARGET_AUTOINC_EN.
module i2c_target #(
  parameter logic [6:0] ADDR       = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clock,
  input  logic       reset,
  i2c_target_if.slave bus,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_MACK, ST_IGNORE
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]    meta_q, sync_q, filt_q, prev_q;
  logic [CW-1:0] cnt_q [2];

  state_t     state_q;
  logic [2:0] bitCnt_q;
  logic [7:0] shift_q;
  logic       rw_q, ackOn_q, ptrLoaded_q;
  logic       sdaOe_q, wrValid_q, busy_q;
  logic [7:0] regAddr_q, wrData_q;

  logic       sclRise, sclFall, startDet, stopDet, sdaBit;
  logic [7:0] rxByte;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      meta_q <= {bus.sda_in, bus.scl_in};
      sync_q <= meta_q;
      prev_q <= filt_q;
      // A line only changes after FILTER_LEN consecutive samples disagree with it.
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sclRise  = filt_q[0] & ~prev_q[0];
  assign sclFall  = ~filt_q[0] & prev_q[0];
  assign startDet = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
  assign stopDet  = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];
  assign sdaBit   = filt_q[1];
  assign rxByte   = {shift_q[6:0], sdaBit};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      ackOn_q     <= 1'b0;
      ptrLoaded_q <= 1'b0;
      sdaOe_q     <= 1'b0;
      regAddr_q   <= 8'h00;
      wrData_q    <= 8'h00;
      wrValid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wrValid_q <= 1'b0;
`ifdef I2C_TARGET_AUTOINC_EN
      if (wrValid_q) regAddr_q <= regAddr_q + 8'd1;
`endif
      if (stopDet) begin
        state_q     <= ST_IDLE;
        sdaOe_q     <= 1'b0;
        busy_q      <= 1'b0;
        ackOn_q     <= 1'b0;
        ptrLoaded_q <= 1'b0;
      end else if (startDet) begin
        state_q  <= ST_ADDR;
        bitCnt_q <= 3'd0;
        sdaOe_q  <= 1'b0;
        busy_q   <= 1'b1;
        ackOn_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_REG, ST_WDATA: begin
            if (sclRise) begin
              shift_q  <= rxByte;
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                if (state_q == ST_ADDR) begin
                  rw_q    <= rxByte[0];
                  state_q <= (rxByte[7:1] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                end else if (state_q == ST_REG) begin
                  regAddr_q   <= rxByte;
                  ptrLoaded_q <= 1'b1;
                  state_q     <= ST_REG_ACK;
                end else begin
                  wrData_q  <= rxByte;
                  wrValid_q <= 1'b1;
                  state_q   <= ST_WDATA_ACK;
                end
              end
            end
          end
          // First fall after the byte pulls SDA for the ACK, the second ends the slot.
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (sclFall) begin
              if (!ackOn_q) begin
                sdaOe_q <= 1'b1;
                ackOn_q <= 1'b1;
              end else begin
                ackOn_q  <= 1'b0;
                bitCnt_q <= 3'd0;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                  shift_q <= reg_rdata;
                  sdaOe_q <= ~reg_rdata[7];
                  state_q <= ST_RDATA;
                end else begin
                  sdaOe_q <= 1'b0;
                  state_q <= (state_q == ST_ADDR_ACK && !ptrLoaded_q) ? ST_REG : ST_WDATA;
                end
              end
            end
          end
          // bitCnt counts controller sample edges; it wraps to 0 after the 8th.
          ST_RDATA: begin
            if (sclRise) begin
              bitCnt_q <= bitCnt_q + 3'd1;
            end else if (sclFall) begin
              if (bitCnt_q == 3'd0) begin
                sdaOe_q <= 1'b0;
                state_q <= ST_MACK;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
                sdaOe_q <= ~shift_q[6];
              end
            end
          end
          ST_MACK: begin
            if (sclRise) begin
`ifdef I2C_TARGET_AUTOINC_EN
              regAddr_q <= regAddr_q + 8'd1;
`endif
              if (sdaBit) state_q <= ST_IGNORE;
              else        ackOn_q <= 1'b1;
            end else if (sclFall && ackOn_q) begin
              ackOn_q  <= 1'b0;
              bitCnt_q <= 3'd0;
              shift_q  <= reg_rdata;
              sdaOe_q  <= ~reg_rdata[7];
              state_q  <= ST_RDATA;
            end
          end
          default: begin
            sdaOe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe = sdaOe_q;
  assign reg_addr   = regAddr_q;
  assign wr_data    = wrData_q;
  assign wr_valid   = wrValid_q;
  assign busy       = busy_q;

endmodule
